sm83_bus_arb: RTL

//  Shares the single external memory bus (adr/dout/rd/wr) between the sm83 CPU and one DMA/debug requester.

---
 rtl/sm83_bus_arb.sv | 114 +++++++++++
 1 files changed

// File: rtl/sm83_bus_arb.sv
// Bus arbiter between the sm83 CPU and one DMA/debug requester.
// Ownership is decided once per slot at the ncyc strobe. The CPU has priority, and a starving DMA request can force a CPU hold.
module sm83_bus_arb #(
    parameter int MAX_WAIT = 4,
    parameter bit HOLD_EN  = 1'b1
) (
    input  logic        clk,
    input  logic        nreset,
    input  logic        ncyc,
    input  logic        phi,
    input  logic [15:0] cpu_adr,
    input  logic [7:0]  cpu_dout,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic        cpu_hold,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [15:0] dma_adr,
    input  logic [7:0]  dma_wdata,
    output logic        dma_ack,
    output logic [7:0]  dma_rdata,
    output logic [15:0] mem_adr,
    output logic [7:0]  mem_wdata,
    output logic        mem_rd,
    output logic        mem_wr,
    input  logic [7:0]  mem_rdata,
    output logic        grant_dma,
    output logic [1:0]  dbg_state
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CPU  = 2'd1;
    localparam logic [1:0] S_DMA  = 2'd2;
    localparam logic [1:0] S_HOLD = 2'd3;

    localparam logic [3:0] STARVE_MAX = 4'(MAX_WAIT);

    logic [1:0] state, state_nxt;
    logic [3:0] starve, starve_nxt;
    logic       req_ok;
    logic       cpu_busy;
    logic       unused_phi;

    // phi is informational only; sequencing is driven purely by ncyc.
    assign unused_phi = phi;

    // A request is consumed only if the slot now ending was not DMA,
    // so back-to-back requests interleave with at least one other slot.
    assign req_ok   = dma_req && (state != S_DMA);
    assign cpu_busy = cpu_rd | cpu_wr;

    always_comb begin
        state_nxt = S_IDLE;
        if (state == S_HOLD) begin
            state_nxt = req_ok ? S_DMA : S_IDLE;
        end else if (cpu_busy) begin
            if (req_ok && HOLD_EN && (starve == STARVE_MAX))
                state_nxt = S_HOLD;
            else
                state_nxt = S_CPU;
        end else if (req_ok) begin
            state_nxt = S_DMA;
        end
    end

    always_comb begin
        starve_nxt = starve;
        if ((state_nxt == S_DMA) || !dma_req)
            starve_nxt = 4'd0;
        else if (req_ok && ((state_nxt == S_CPU) || (state_nxt == S_HOLD)))
            starve_nxt = (starve == STARVE_MAX) ? starve : starve + 4'd1;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= S_IDLE;
            starve    <= 4'd0;
            cpu_hold  <= 1'b0;
            dma_ack   <= 1'b0;
            dma_rdata <= 8'h00;
        end else begin
            dma_ack <= 1'b0;
            if (ncyc) begin
                state    <= state_nxt;
                starve   <= starve_nxt;
                cpu_hold <= (state_nxt == S_HOLD);
                // Completion of a DMA slot: capture read data, pulse ack.
                if (state == S_DMA) begin
                    dma_ack <= 1'b1;
                    if (!dma_we)
                        dma_rdata <= mem_rdata;
                end
            end
        end
    end

    always_comb begin
        if (state == S_DMA) begin
            mem_adr   = dma_adr;
            mem_wdata = dma_wdata;
            mem_rd    = ~dma_we;
            mem_wr    = dma_we;
        end else begin
            mem_adr   = cpu_adr;
            mem_wdata = cpu_dout;
            mem_rd    = cpu_rd;
            mem_wr    = cpu_wr;
        end
    end

    assign grant_dma = (state == S_DMA);
    assign dbg_state = state;

endmodule
